// File: rtl/phase_accumulator_pkg.sv
// rtl/phase_accumulator_pkg.sv - shared state encodings and constants for the phase accumulator
// Purpose: FSM state type and the read-miss pattern returned for out-of-range addresses.
// Ports: none (package).
package phase_accumulator_pkg;

   typedef enum logic [2:0] {
      PA_IDLE   = 3'd0,
      PA_HOLD   = 3'd1,
      PA_SETTLE = 3'd2,
      PA_MEAS   = 3'd3,
      PA_DONE   = 3'd4
   } pa_state_t;

   // Returned by any read mux when the address is past the last entry.
   localparam logic [31:0] RD_MISS = 32'hAAAA_AAAA;

endpackage

// File: rtl/phase_accumulator_sync_2ff.sv
// rtl/phase_accumulator_sync_2ff.sv - two-flop synchroniser bank
// Purpose: bring W asynchronous bits into the clk domain through two flops.
// Ports: i_clk clock; i_rst sync active-high reset; i_d async input bits; o_q synchronised bits.
module sync_2ff #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/phase_accumulator.sv
// rtl/phase_accumulator.sv - runs an Ising solve and accumulates per-spin phase agreement
// Purpose: sequences ising_rstn (hold, settle, measure), counts cycles each spin tap equals
//          the reference tap, resolves spins at window end and serves counts for readout.
// Ports: clk/axi_rst clock and sync active-high reset; right_col async phase taps;
//        ising_rstn oscillator reset (active low); start/settle_cyc/window_cyc run request
//        and timing; busy/done/spins run status and result; rd_addr/rdata count readout.
module phase_accumulator
   import phase_accumulator_pkg::*;
#(
   parameter int N           = 8,
   parameter int CNT_W       = 32,
   parameter int REF_IDX     = 0,
   parameter int HOLD_CYCLES = 16,
   // One extra address bit so out-of-range indices are expressible even when N is a power of two.
   localparam int RD_W       = $clog2(N) + 1
) (
   input  logic            clk,
   input  logic            axi_rst,
   input  logic [N-1:0]    right_col,
   output logic            ising_rstn,
   input  logic            start,
   input  logic [31:0]     settle_cyc,
   input  logic [31:0]     window_cyc,
   output logic            busy,
   output logic            done,
   output logic [N-1:0]    spins,
   input  logic [RD_W-1:0] rd_addr,
   output logic [31:0]     rdata
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   pa_state_t        r_state;
   pa_state_t        w_state_nxt;
   logic [31:0]      r_cyc;
   logic [31:0]      r_settle;
   logic [31:0]      r_win;
   logic [N-1:0]     w_s;
   logic [N-1:0]     w_match;
   logic [N-1:0]     w_spin_nxt;
   logic [N-1:0]     r_spins;
   logic [CNT_W-1:0] r_cnt     [N];
   logic [CNT_W-1:0] w_cnt_nxt [N];
   logic [31:0]      r_rdata;
   logic             w_accept;
   logic             w_meas_end;

   sync_2ff #(.W(N)) u_sync (
      .i_clk (clk),
      .i_rst (axi_rst),
      .i_d   (right_col),
      .o_q   (w_s)
   );

   assign w_accept   = start && ((r_state == PA_IDLE) || (r_state == PA_DONE));
   assign w_meas_end = (r_state == PA_MEAS) && (w_state_nxt == PA_DONE);

   // Next state and state-decoded outputs.
   always_comb begin
      w_state_nxt = r_state;
      ising_rstn  = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         PA_IDLE: begin
            if (start) w_state_nxt = PA_HOLD;
         end
         PA_HOLD: begin
            busy = 1'b1;
            if (r_cyc == 32'(HOLD_CYCLES - 1)) begin
               if (r_settle != 32'd0)   w_state_nxt = PA_SETTLE;
               else if (r_win != 32'd0) w_state_nxt = PA_MEAS;
               else                     w_state_nxt = PA_DONE;
            end
         end
         PA_SETTLE: begin
            busy       = 1'b1;
            ising_rstn = 1'b1;
            if (r_cyc == r_settle - 32'd1)
               w_state_nxt = (r_win != 32'd0) ? PA_MEAS : PA_DONE;
         end
         PA_MEAS: begin
            busy       = 1'b1;
            ising_rstn = 1'b1;
            if (r_cyc == r_win - 32'd1) w_state_nxt = PA_DONE;
         end
         PA_DONE: begin
            done       = 1'b1;
            ising_rstn = 1'b1;
            if (start) w_state_nxt = PA_HOLD;
         end
         default: w_state_nxt = PA_IDLE;
      endcase
   end

   // Phase cycle counter restarts at every state change so each phase counts from 0.
   always_ff @(posedge clk) begin
      if (axi_rst) begin
         r_state  <= PA_IDLE;
         r_cyc    <= '0;
         r_settle <= '0;
         r_win    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cyc   <= (w_state_nxt != r_state) ? 32'd0 : r_cyc + 32'd1;
         if (w_accept) begin
            r_settle <= settle_cyc;
            r_win    <= window_cyc;
         end
      end
   end

   // Per-spin match, saturating increment and majority decision. The decision uses the
   // post-increment count so the final window cycle is included when DONE is entered.
   for (genvar gi = 0; gi < N; gi++) begin : g_spin
      assign w_match[gi]    = (w_s[gi] == w_s[REF_IDX]);
      assign w_cnt_nxt[gi]  = (w_match[gi] && (r_cnt[gi] != CNT_MAX)) ? r_cnt[gi] + 1'b1 : r_cnt[gi];
      assign w_spin_nxt[gi] = ({w_cnt_nxt[gi], 1'b0} >= {1'b0, r_win[CNT_W-1:0]});
   end

   always_ff @(posedge clk) begin
      if (axi_rst || w_accept) begin
         for (int i = 0; i < N; i++) r_cnt[i] <= '0;
         r_spins <= '0;
      end else begin
         if (r_state == PA_MEAS) begin
            for (int i = 0; i < N; i++) r_cnt[i] <= w_cnt_nxt[i];
         end
         if (w_meas_end) r_spins <= w_spin_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (axi_rst)                    r_rdata <= '0;
      else if (32'(rd_addr) >= 32'(N)) r_rdata <= RD_MISS;
      else                            r_rdata <= 32'(r_cnt[rd_addr[RD_W-2:0]]);
   end

   assign spins = r_spins;
   assign rdata = r_rdata;

endmodule

// File: tb/tb_phase_accumulator.sv
// tb/tb_phase_accumulator.sv - self-checking bench for phase_accumulator
module tb_phase_accumulator;

   localparam int N  = 8;
   localparam int RW = $clog2(N) + 1;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          axi_rst;
   logic          start;
   logic [N-1:0]  right_col;
   logic [31:0]   settle_cyc;
   logic [31:0]   window_cyc;
   logic [RW-1:0] rd_addr;

   logic          a_rstn, a_busy, a_done;
   logic [N-1:0]  a_spins;
   logic [31:0]   a_rdata;
   logic          b_rstn, b_busy, b_done;
   logic [N-1:0]  b_spins;
   logic [31:0]   b_rdata;

   phase_accumulator #(.N(N), .CNT_W(32), .REF_IDX(0), .HOLD_CYCLES(16)) dut_a (
      .clk(clk), .axi_rst(axi_rst), .right_col(right_col), .ising_rstn(a_rstn),
      .start(start), .settle_cyc(settle_cyc), .window_cyc(window_cyc),
      .busy(a_busy), .done(a_done), .spins(a_spins), .rd_addr(rd_addr), .rdata(a_rdata)
   );

   phase_accumulator #(.N(N), .CNT_W(4), .REF_IDX(0), .HOLD_CYCLES(16)) dut_b (
      .clk(clk), .axi_rst(axi_rst), .right_col(right_col), .ising_rstn(b_rstn),
      .start(start), .settle_cyc(settle_cyc), .window_cyc(window_cyc),
      .busy(b_busy), .done(b_done), .spins(b_spins), .rd_addr(rd_addr), .rdata(b_rdata)
   );

   int n_chk = 0;
   int n_err = 0;
   int kk    = 0;
   int mode  = 0;
   int match_len = 0;

   typedef struct packed {
      logic          sel_b;
      logic [RW-1:0] addr;
      logic [31:0]   exp;
   } sb_t;
   sb_t sbq[$];

   typedef struct {
      logic [RW-1:0] addr;
      logic [31:0]   exp;
   } vec_t;
   vec_t vecs[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Tap pattern for the value captured at edge k after the accepting edge.
   // mode 0: all in phase; 1: bits 0-3 in phase, 4-7 inverted;
   // 2: spin 5 matches only for k in [25, 25+match_len-1] (counted edges for settle=10).
   function automatic logic [N-1:0] pat(input int k);
      logic         r;
      logic [N-1:0] v;
      r = k[0];
      case (mode)
         0:       v = {N{r}};
         1:       v = {{4{~r}}, {4{r}}};
         default: begin
            v = {N{r}};
            if (!(k >= 25 && k < 25 + match_len)) v[5] = ~r;
         end
      endcase
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      kk++;
      right_col = pat(kk + 1);
   endtask

   task automatic rd_check(input logic sel_b, input logic [RW-1:0] a, input logic [31:0] e);
      sb_t it;
      rd_addr = a;
      sbq.push_back({sel_b, a, e});
      tick();
      it = sbq.pop_front();
      chk($sformatf("rdata_%s[%0d]", it.sel_b ? "b" : "a", it.addr),
          it.sel_b ? b_rdata : a_rdata, it.exp);
   endtask

   // Pulse start, then step until done (bounded). lo = busy cycles with ising_rstn low,
   // hi = busy cycles with ising_rstn high, dk = cycle index where done first seen (-1 if never).
   task automatic run(input int st, input int wn, input int inj, output int lo, output int hi, output int dk);
      settle_cyc = st;
      window_cyc = wn;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      kk         = 0;
      right_col  = pat(1);
      settle_cyc = 32'd3;   // changing inputs after accept must not affect the run
      window_cyc = 32'd7;
      lo = 0; hi = 0; dk = -1;
      while (dk < 0 && kk < 2000) begin
         if (a_done) dk = kk;
         else begin
            if (a_busy && !a_rstn) lo++;
            if (a_busy && a_rstn)  hi++;
            if (kk == inj) start = 1'b1;
            tick();
            start = 1'b0;
         end
      end
   endtask

   int lo, hi, dk;
   int saw_done;

   initial begin
      axi_rst = 1'b1; start = 1'b0; right_col = '0;
      settle_cyc = '0; window_cyc = '0; rd_addr = '0;
      repeat (3) tick();
      chk("rst_rstn", {31'd0, a_rstn}, 32'd0);
      chk("rst_busy", {31'd0, a_busy}, 32'd0);
      chk("rst_done", {31'd0, a_done}, 32'd0);
      chk("rst_spins", {24'd0, a_spins}, 32'd0);
      chk("rst_rdata", a_rdata, 32'd0);
      axi_rst = 1'b0;
      tick();

      // Phase run: in-phase low nibble, inverted high nibble.
      mode = 1;
      run(10, 100, -1, lo, hi, dk);
      chk("phase_hold_cycles", lo, 32'd16);
      chk("phase_busy_hi_cycles", hi, 32'd110);
      chk("phase_done_at", dk, 32'd126);
      chk("phase_spins", {24'd0, a_spins}, 32'h0F);
      for (int i = 0; i < 8; i++) begin
         vecs[i].addr = RW'(i);
         vecs[i].exp  = (i < 4) ? 32'd100 : 32'd0;
      end
      vecs[8].addr = 4'd9;  vecs[8].exp = 32'hAAAA_AAAA;
      vecs[9].addr = 4'd15; vecs[9].exp = 32'hAAAA_AAAA;
      for (int i = 0; i < 10; i++) rd_check(1'b0, vecs[i].addr, vecs[i].exp);
      chk("phase_done_held", {31'd0, a_done}, 32'd1);

      // Start in DONE: done drops next cycle and counters clear.
      rd_addr = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_done", {31'd0, a_done}, 32'd0);
      chk("restart_busy", {31'd0, a_busy}, 32'd1);
      rd_check(1'b0, 4'd0, 32'd0);
      axi_rst = 1'b1; tick(); axi_rst = 1'b0; tick();

      // Start pulsed during SETTLE is ignored; timing matches settle+window exactly.
      mode = 0;
      run(10, 50, 20, lo, hi, dk);
      chk("hs_hold_cycles", lo, 32'd16);
      chk("hs_busy_hi_cycles", hi, 32'd60);
      chk("hs_done_at", dk, 32'd76);

      // Saturation: 4-bit counters stop at 15 while 32-bit ones reach 40.
      mode = 0;
      run(10, 40, -1, lo, hi, dk);
      chk("sat_done_at", dk, 32'd66);
      chk("sat_spins_a", {24'd0, a_spins}, 32'hFF);
      chk("sat_spins_b", {24'd0, b_spins}, 32'hFF);
      rd_check(1'b1, 4'd0, 32'd15);
      rd_check(1'b1, 4'd6, 32'd15);
      rd_check(1'b0, 4'd6, 32'd40);

      // Tie: exactly half the window resolves in-phase, one fewer does not.
      mode = 2; match_len = 50;
      run(10, 100, -1, lo, hi, dk);
      chk("tie50_spins", {24'd0, a_spins}, 32'hFF);
      rd_check(1'b0, 4'd5, 32'd50);
      match_len = 49;
      run(10, 100, -1, lo, hi, dk);
      chk("tie49_spins", {24'd0, a_spins}, 32'hDF);
      rd_check(1'b0, 4'd5, 32'd49);

      // Zero-length window: DONE right after SETTLE, nothing counted.
      mode = 0;
      run(10, 0, -1, lo, hi, dk);
      chk("win0_done_at", dk, 32'd26);
      chk("win0_spins", {24'd0, a_spins}, 32'h00);
      rd_check(1'b0, 4'd0, 32'd0);

      // Reset mid-MEAS, with start held during reset.
      mode = 0;
      settle_cyc = 32'd2; window_cyc = 32'd100; start = 1'b1;
      tick();
      start = 1'b0; kk = 0;
      while (kk < 25) tick();
      chk("pre_rst_meas", {30'd0, a_busy, a_rstn}, 32'd3);
      axi_rst = 1'b1; start = 1'b1;
      tick();
      chk("midrst_rstn", {31'd0, a_rstn}, 32'd0);
      chk("midrst_busy", {31'd0, a_busy}, 32'd0);
      chk("midrst_done", {31'd0, a_done}, 32'd0);
      chk("midrst_rdata", a_rdata, 32'd0);
      tick(); tick();
      axi_rst = 1'b0; start = 1'b0;
      tick();
      chk("post_rst_idle", {29'd0, a_busy, a_done, a_rstn}, 32'd0);
      saw_done = 0;
      for (int i = 0; i < 150; i++) begin
         if (a_done || a_busy) saw_done = 1;
         tick();
      end
      chk("post_rst_stays_idle", saw_done, 32'd0);
      rd_check(1'b0, 4'd0, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
